// File: rtl/thumb_fetch_unit_if.sv
// thumb_fetch_unit_if
//   Bundles the instruction-memory bus, the branch/halt controls and the
//   decode-side valid/ready handshake of the fetch stage.
//   master : the fetch unit (drives strobe, address and the decode head)
//   slave  : the surrounding core/memory (drives data, branch, halt, ready)
interface thumb_fetch_unit_if #(
    parameter int WORD_SIZE  = 32,
    parameter int HWORD_SIZE = 16
);
    logic                  read_instruction_n;
    logic [WORD_SIZE-1:0]  instruction_address;
    logic [HWORD_SIZE-1:0] instruction;
    logic                  branch_valid;
    logic [WORD_SIZE-1:0]  branch_target;
    logic                  halt;
    logic                  dec_valid;
    logic [HWORD_SIZE-1:0] dec_instr;
    logic [WORD_SIZE-1:0]  dec_pc;
    logic                  dec_ready;

    modport master (
        output read_instruction_n, instruction_address,
        output dec_valid, dec_instr, dec_pc,
        input  instruction, branch_valid, branch_target, halt, dec_ready
    );

    modport slave (
        input  read_instruction_n, instruction_address,
        input  dec_valid, dec_instr, dec_pc,
        output instruction, branch_valid, branch_target, halt, dec_ready
    );
endinterface

// File: rtl/thumb_fetch_unit.sv
// thumb_fetch_unit
//   Instruction fetch stage: strobes instruction memory, waits READ_WAIT
//   extra cycles, captures halfwords into a prefetch queue and presents the
//   queue head to decode over valid/ready. A branch flushes everything.
//   clk     : system clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : thumb_fetch_unit_if.master (memory bus, branch/halt, decode)
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no fetch in flight; start one when a slot is free and !halt
//   REQ     | strobe low, counting wait states, capture when counter is 0
//   RECOVER | one-cycle strobe-high gap after a capture or a branch
module thumb_fetch_unit #(
    parameter int                WORD_SIZE   = 32,
    parameter int                HWORD_SIZE  = 16,
    parameter int                QUEUE_DEPTH = 4,
    parameter int                READ_WAIT   = 0,
    parameter logic [WORD_SIZE-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    thumb_fetch_unit_if.master      bus
);
    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RECOVER} state_t;

    state_t                state;
    logic                  read_n_q;
    logic [WORD_SIZE-1:0]  addr_q;
    logic [WORD_SIZE-1:0]  pc;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [HWORD_SIZE-1:0] q_instr [QUEUE_DEPTH];
    logic [WORD_SIZE-1:0]  q_pc    [QUEUE_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;

    logic pop;
    logic capture;
    logic can_fetch;

    assign bus.read_instruction_n  = read_n_q;
    assign bus.instruction_address = addr_q;
    assign bus.dec_valid           = (count != '0);
    assign bus.dec_instr           = q_instr[head];
    assign bus.dec_pc              = q_pc[head];

    assign pop     = bus.dec_valid && bus.dec_ready;
    assign capture = (state == REQ) && (wait_cnt == '0);
    // The slot for a new fetch is reserved on entry to REQ: only one fetch
    // is ever in flight, so counting after this cycle's pop is sufficient.
    assign can_fetch = !bus.halt && ((count - CNT_W'(pop)) < CNT_W'(QUEUE_DEPTH));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            read_n_q <= 1'b1;
            addr_q   <= RESET_PC;
            pc       <= RESET_PC;
            wait_cnt <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (bus.branch_valid) begin
            // Branch wins over any pop, push or in-flight fetch.
            state    <= RECOVER;
            read_n_q <= 1'b1;
            wait_cnt <= '0;
            pc       <= bus.branch_target & ~WORD_SIZE'(1);
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (pop)
                head <= head + PTR_W'(1);
            if (capture) begin
                q_instr[tail] <= bus.instruction;
                q_pc[tail]    <= addr_q;
                tail          <= tail + PTR_W'(1);
            end
            count <= count + CNT_W'(capture) - CNT_W'(pop);

            case (state)
                REQ: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end else begin
                        pc       <= pc + WORD_SIZE'(2);
                        state    <= RECOVER;
                        read_n_q <= 1'b1;
                    end
                end
                default: begin
                    if (can_fetch) begin
                        state    <= REQ;
                        read_n_q <= 1'b0;
                        addr_q   <= pc;
                        wait_cnt <= WAIT_W'(READ_WAIT);
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
